// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID latch with field decode, fetch/stall counters.
// Build option: define IF_BRANCH_FLUSH_EN to squash the wrong-path instruction on a redirect.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              PC_enable,
    input  logic              IFID_LE,
    input  logic              Branch_taken,
    input  logic [31:0]       Target_Addr,
    input  logic [31:0]       Imem_Data,
    output logic [31:0]       Imem_Addr,
    output logic [31:0]       IFID_Inst_Out,
    output logic [31:0]       IFID_PC4_Out,
    output logic [23:0]       IFID_Offset_Out,
    output logic [3:0]        IFID_Cond_Codes,
    output logic [3:0]        IFID_Rn_Out,
    output logic [3:0]        IFID_Rd_Out,
    output logic [3:0]        IFID_Rm_Out,
    output logic [11:0]       IFID_Shift_Amount_Out,
    output logic              IFID_Valid_Out,
    output logic [1:0]        State_Out,
    output logic [CNT_W-1:0]  Fetch_Count,
    output logic [CNT_W-1:0]  Stall_Count
);

    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_STALL  = 2'b01;
    localparam logic [1:0] ST_SQUASH = 2'b10;

    logic [31:0]      pc_r;
    logic [31:0]      inst_r;
    logic [31:0]      pc4_r;
    logic             valid_r;
    logic [1:0]       state_r;
    logic [CNT_W-1:0] fetch_cnt_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [31:0]      pc4_s;
    logic             stall_s;
    logic             unused_tgt_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign pc4_s        = pc_r + 32'd4;
    // A half stall (only one enable low) is promoted to a full stall so nothing is dropped.
    assign stall_s      = ~PC_enable | ~IFID_LE;
    assign unused_tgt_s = ^Target_Addr[1:0];

    // PC, IF/ID latch, state and counters; reset > redirect > stall > advance.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            pc_r        <= RESET_PC;
            inst_r      <= 32'h0000_0000;
            pc4_r       <= 32'h0000_0000;
            valid_r     <= 1'b0;
            state_r     <= ST_RUN;
            fetch_cnt_r <= {CNT_W{1'b0}};
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (Branch_taken) begin
            pc_r <= {Target_Addr[31:2], 2'b00};
`ifdef IF_BRANCH_FLUSH_EN
            inst_r  <= 32'h0000_0000;
            pc4_r   <= 32'h0000_0000;
            valid_r <= 1'b0;
            state_r <= ST_SQUASH;
`else
            inst_r      <= Imem_Data;
            pc4_r       <= pc4_s;
            valid_r     <= 1'b1;
            state_r     <= ST_RUN;
            fetch_cnt_r <= sat_inc(fetch_cnt_r);
`endif
        end else if (stall_s) begin
            state_r     <= ST_STALL;
            stall_cnt_r <= sat_inc(stall_cnt_r);
        end else begin
            pc_r        <= pc4_s;
            inst_r      <= Imem_Data;
            pc4_r       <= pc4_s;
            valid_r     <= 1'b1;
            state_r     <= ST_RUN;
            fetch_cnt_r <= sat_inc(fetch_cnt_r);
        end
    end

    assign Imem_Addr             = pc_r;
    assign IFID_Inst_Out         = inst_r;
    assign IFID_PC4_Out          = pc4_r;
    assign IFID_Valid_Out        = valid_r;
    assign State_Out             = state_r;
    assign Fetch_Count           = fetch_cnt_r;
    assign Stall_Count           = stall_cnt_r;
    assign IFID_Offset_Out       = inst_r[23:0];
    assign IFID_Cond_Codes       = inst_r[31:28];
    assign IFID_Rn_Out           = inst_r[19:16];
    assign IFID_Rd_Out           = inst_r[15:12];
    assign IFID_Rm_Out           = inst_r[3:0];
    assign IFID_Shift_Amount_Out = inst_r[11:0];

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the five-stage ARM pipeline. Owns the program counter, drives the instruction RAM address, and applies stall and branch-redirect requests from the hazard unit and condition handler. Also contains the IF/ID pipeline latch, including field decode for the ID stage, and keeps fetch and stall performance counters. Sits between the instruction RAM and the register-file/control-unit ID stage.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 16, width of the performance counters

- CLK  in  1  pipeline clock; all state updates on the rising edge
- CLR  in  1  reset, synchronous, active-high
- PC_enable  in  1  from hazard unit; 0 = hold PC (load-use stall)
- IFID_LE  in  1  from hazard unit; 0 = hold IF/ID latch
- Branch_taken  in  1  from condition handler; redirect request
- Target_Addr  in  32  branch target from ID adder
- Imem_Data  in  32  instruction word; combinational read of Imem_Addr
- Imem_Addr  out  32  current PC, combinational from the PC register
- IFID_Inst_Out  out  32  latched instruction
- IFID_PC4_Out  out  32  latched PC+4 of that instruction
- IFID_Offset_Out  out  24  Inst[23:0]
- IFID_Cond_Codes  out  4  Inst[31:28]
- IFID_Rn_Out / IFID_Rd_Out / IFID_Rm_Out  out  4 each  Inst[19:16] / Inst[15:12] / Inst[3:0]
- IFID_Shift_Amount_Out  out  12  Inst[11:0]
- IFID_Valid_Out  out  1  1 = latch holds a real fetched instruction
- State_Out  out  2  00 RUN, 01 STALL, 10 SQUASH (registered)
- Fetch_Count  out  CNT_W  instructions latched valid
- Stall_Count  out  CNT_W  cycles spent in STALL

## Operation
- Reset (CLR=1 at an edge):
  - PC = RESET_PC.
  - All IF/ID fields = 0 (the all-zero word is the pipeline NOP).
  - IFID_Valid_Out = 0, State_Out = RUN, both counters = 0.
  - Reset has priority over every other input.
- Edge priority with CLR=0: Branch_taken, then stall, then normal advance.
- Branch_taken=1:
  - PC <= {Target_Addr[31:2], 2'b00}.
  - The IF/ID action depends on IF_BRANCH_FLUSH_EN (see Configuration).
  - This case overrides PC_enable=0 and IFID_LE=0.
- Stall, when PC_enable=0 or IFID_LE=0:
  - PC holds and the IF/ID latch holds, including Valid.
  - State becomes STALL and Stall_Count increments.
  - A PC_enable/IFID_LE mismatch is treated as a full stall, so no instruction is ever dropped.
- Normal advance:
  - PC <= PC + 4, mod 2^32; wrap from 32'hFFFF_FFFC to 0 is silent.
  - IF/ID <= {Imem_Data, PC+4}, Valid=1.
  - State becomes RUN.
- Fetch_Count increments on every edge where the latch loads with Valid=1.
- Both counters saturate at all-ones and never wrap.
- Decoded field outputs are wires sliced from the latched instruction.

## Timing
- Imem_Addr follows the PC register with no delay.
- Imem_Data must settle within the same cycle.
- The instruction at PC appears on the IFID outputs one edge after it is addressed.
- Redirect: the target address is driven on Imem_Addr in the cycle after the Branch_taken edge.
  - The target instruction reaches IF/ID on the following edge, i.e. 2 edges after Branch_taken.
- After a stall releases, fetch resumes on the next edge with no lost or duplicated instruction.
- Reset mid-stall or mid-redirect: reset wins, and the first fetch from RESET_PC latches on the first edge with CLR=0.
- Branch_taken asserted on consecutive edges: each redirect takes effect and the last target wins.

## Configuration
- IF_BRANCH_FLUSH_EN defined:
  - On Branch_taken, IF/ID <= all-zero NOP, Valid=0, State=SQUASH.
  - The wrong-path instruction is squashed.
- IF_BRANCH_FLUSH_EN undefined:
  - On Branch_taken, IF/ID <= {Imem_Data, PC+4}, Valid=1, State=RUN.
  - This is a one-instruction branch delay slot.
  - Fetch_Count increments.

## Test plan
- Reset: CLR=1 for 2 edges with RESET_PC=0 -> Imem_Addr=0, IFID_Inst_Out=0, Valid=0, counters 0. Then release with RAM words A,B,C at 0,4,8 -> IF/ID shows A, B, C on successive edges, IFID_PC4_Out=4, 8, 12, Fetch_Count=3.
- Stall: PC_enable=IFID_LE=0 for 3 edges while at PC=8 -> Imem_Addr stays 8, IF/ID holds B, Stall_Count=3. Release -> C latches next edge and is not duplicated.
- Branch with flush: at PC=12, Branch_taken=1, Target_Addr=32'h40 -> next Imem_Addr=0x40, IF/ID=0, Valid=0, State=SQUASH. The word at 0x40 latches on the following edge.
- Branch without flush: same stimulus with the macro undefined -> the word at 12 latches with Valid=1 (delay slot) and Imem_Addr=0x40.
- Simultaneous events: Branch_taken=1 with PC_enable=0 -> redirect occurs and Stall_Count is unchanged. Unaligned Target_Addr=0x43 -> Imem_Addr=0x40.
- Saturation and wrap: with CNT_W=4, 20 stall cycles -> Stall_Count=15. PC=32'hFFFF_FFFC advancing -> Imem_Addr=0.
